hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller that generates the stall, flush and forwarding controls consumed by the F/D/E/M stage registers.
- Watches the decode, execute and memory stage-register outputs; drives load-use stalls, taken-branch shadow flushes, operand-forwarding selects and the ebreak halt.
- Sits beside the datapath; all control outputs are combinational from registered state and stage-register outputs, so each is valid before the next _clk edge.

Parameters:
- BRANCH_SHADOW, 2, cycles of flush asserted after a taken branch resolves in E (legal range 1..3).
- LOAD_SRC, 2'b01, wb_src encoding that marks a load (result available only after M).

Ports:
- _clk  in  1  clock
- _rst  in  1  synchronous active-high reset
- _d_valid  in  1  decode-stage entry valid
- _d_rs1  in  5  decode-stage source 1
- _d_rs2  in  5  decode-stage source 2
- _d_use_rs1  in  1  decode instruction reads rs1
- _d_use_rs2  in  1  decode instruction reads rs2
- _e_valid  in  1  execute-stage entry valid
- _e_rd  in  5  execute-stage destination
- _e_wb_we  in  1  execute-stage writes back
- _e_wb_src  in  2  execute-stage writeback source
- _e_branch_taken  in  1  branch in E resolved taken
- _m_valid  in  1  memory-stage entry valid
- _m_rd  in  5  memory-stage destination
- _m_wb_we  in  1  memory-stage writes back
- _m_ebreak  in  1  memory-stage holds ebreak
- sig_lw_blocked_  out  1  hold F and D, inject bubble into E
- sig_flush_  out  1  invalidate F and D entries (branch shadow)
- fwd_rs1_sel_  out  2  0 regfile, 1 E result, 2 M writeback value
- fwd_rs2_sel_  out  2  same encoding for rs2
- halted_  out  1  core halted on ebreak
- stall_cycles_  out  32  perf counter (see Optional Feature)
- flush_cycles_  out  32  perf counter (see Optional Feature)

Behaviour:
- State register: IDLE, LW_STALL, BR_FLUSH, HALT. Reset: IDLE, shadow counter 0, halted_ 0, perf counters 0. Outputs in IDLE with all valids low: sig_lw_blocked_ 0, sig_flush_ 0, selects 0.
- Load-use condition (lu):
  - _d_valid, _e_valid, _e_wb_we all high, _e_wb_src==LOAD_SRC, _e_rd!=0.
  - Either (_d_use_rs1 and _d_rs1==_e_rd) or (_d_use_rs2 and _d_rs2==_e_rd).
- IDLE:
  - If _m_valid and _m_ebreak -> HALT.
  - Else if _e_valid and _e_branch_taken -> sig_flush_=1 this cycle; counter<=BRANCH_SHADOW-1; go BR_FLUSH if counter nonzero, else stay IDLE.
  - Else if lu -> sig_lw_blocked_=1 this cycle, go LW_STALL.
- LW_STALL:
  - sig_lw_blocked_=0; load is now in M and is forwarded with select 2.
  - Exactly one stall cycle per load-use pair; lu is not re-evaluated as a new stall because E holds a bubble.
  - Branch/ebreak checks apply as in IDLE; next state IDLE.
- BR_FLUSH:
  - sig_flush_=1 and sig_lw_blocked_=0 regardless of lu.
  - Counter decrements each cycle; leave for IDLE on the cycle it reads 0 (flush still asserted that cycle).
  - Total flush length = BRANCH_SHADOW cycles.
- HALT: sig_lw_blocked_=1, sig_flush_=1, halted_=1 (registered, asserted the cycle after entry). Sticky until _rst.
- Priority (highest first): _rst, ebreak in M, taken branch in E, load-use.
- Forwarding (per source, combinational, all states except HALT):
  - Select 1 when _e_valid, _e_wb_we, _e_rd!=0, _e_rd==rs, and _e_wb_src!=LOAD_SRC.
  - Else select 2 when _m_valid, _m_wb_we, _m_rd!=0, _m_rd==rs.
  - Else select 0. E beats M when both match. x0 never forwards.
  - A load in E never produces select 1.
- Reset mid-operation: any state -> IDLE next edge, counter cleared, outputs deasserted the cycle after _rst sampled high.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - stall_cycles_ increments on every cycle sig_lw_blocked_ is high outside HALT.
  - flush_cycles_ increments on every cycle sig_flush_ is high outside HALT.
  - Both saturate at 32'hFFFFFFFF and clear on _rst.
- When undefined: both ports remain and are tied to 0; no counter flops.

Test Plan:
- lw x5 in E (_e_wb_src=01, _e_rd=5); add x6,x5,x1 in D -> sig_lw_blocked_=1 exactly one cycle. Next cycle fwd_rs1_sel_=2 with x5 in M.
- add x7 in E, sub x8 reads x7 in D -> sig_lw_blocked_=0, fwd_rs1_sel_=1. Same rd also in M -> still 1.
- Taken branch in E, BRANCH_SHADOW=2 -> sig_flush_ high 2 cycles. Load-use present during those cycles -> sig_lw_blocked_ stays 0.
- _e_rd=0 with lw and D reading x0 -> no stall, selects 0.
- _m_ebreak with _m_valid -> halted_=1 next cycle, stalls and flush held high. _rst=1 one cycle -> all outputs 0, state IDLE.
- HAZARD_PERF_EN defined: 3 load-use stalls + 1 taken branch (shadow 2) -> stall_cycles_=3, flush_cycles_=2.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for an F/D/E/M pipeline.
//
// Generates load-use stalls, taken-branch shadow flushes, operand forwarding
// selects and the sticky ebreak halt. All control outputs are combinational
// from registered state and stage-register outputs.
//
// Optional feature: define HAZARD_PERF_EN to enable saturating stall/flush
// cycle counters. When undefined, stall_cycles_ and flush_cycles_ read 0.
//
// Ports:
//   _clk, _rst               clock, synchronous active-high reset
//   _d_*                     decode-stage valid, sources and source-use flags
//   _e_*                     execute-stage valid, rd, writeback enable/source,
//                            branch-taken
//   _m_*                     memory-stage valid, rd, writeback enable, ebreak
//   sig_lw_blocked_          hold F and D, inject bubble into E
//   sig_flush_               invalidate F and D entries
//   fwd_rs1_sel_/rs2_sel_    0 regfile, 1 E result, 2 M writeback value
//   halted_                  core halted on ebreak (sticky until reset)
//   stall_cycles_            stall perf counter
//   flush_cycles_            flush perf counter
module hazard_ctrl #(
   parameter int unsigned BRANCH_SHADOW = 2,
   parameter logic [1:0]  LOAD_SRC      = 2'b01
) (
   input  logic        _clk,
   input  logic        _rst,
   input  logic        _d_valid,
   input  logic [4:0]  _d_rs1,
   input  logic [4:0]  _d_rs2,
   input  logic        _d_use_rs1,
   input  logic        _d_use_rs2,
   input  logic        _e_valid,
   input  logic [4:0]  _e_rd,
   input  logic        _e_wb_we,
   input  logic [1:0]  _e_wb_src,
   input  logic        _e_branch_taken,
   input  logic        _m_valid,
   input  logic [4:0]  _m_rd,
   input  logic        _m_wb_we,
   input  logic        _m_ebreak,
   output logic        sig_lw_blocked_,
   output logic        sig_flush_,
   output logic [1:0]  fwd_rs1_sel_,
   output logic [1:0]  fwd_rs2_sel_,
   output logic        halted_,
   output logic [31:0] stall_cycles_,
   output logic [31:0] flush_cycles_
);

   typedef enum logic [1:0] {StIdle, StLwStall, StBrFlush, StHalt} state_e;

   // Remaining shadow cycles loaded when a taken branch resolves.
   localparam logic [1:0] ShadowInit = 2'(BRANCH_SHADOW - 1);

   state_e     state_q, state_d;
   logic [1:0] shadow_q, shadow_d;
   logic       halted_q;
   logic       lu, br, eb;

   assign eb = _m_valid & _m_ebreak;
   assign br = _e_valid & _e_branch_taken;

   // Load in E whose destination is read by the instruction in D.
   assign lu = _d_valid & _e_valid & _e_wb_we & (_e_wb_src == LOAD_SRC) & (_e_rd != 5'd0) &
               ((_d_use_rs1 & (_d_rs1 == _e_rd)) | (_d_use_rs2 & (_d_rs2 == _e_rd)));

   // State register
   always_ff @(posedge _clk) begin
      if (_rst) begin
         state_q  <= StIdle;
         shadow_q <= 2'd0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         if (state_d == StHalt) halted_q <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      unique case (state_q)
         StIdle, StLwStall: begin
            if (eb) begin
               state_d = StHalt;
            end else if (br) begin
               shadow_d = ShadowInit;
               state_d  = (ShadowInit != 2'd0) ? StBrFlush : StIdle;
            end else if (state_q == StIdle && lu) begin
               state_d = StLwStall;
            end else begin
               state_d = StIdle;
            end
         end
         StBrFlush: begin
            if (eb) begin
               state_d = StHalt;
            end else begin
               shadow_d = shadow_q - 2'd1;
               // Last shadow cycle once the decremented count reaches zero.
               if (shadow_q <= 2'd1) state_d = StIdle;
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      // A load in E has no result yet, so it never forwards from E.
      if (_e_valid && _e_wb_we && _e_rd != 5'd0 && _e_rd == rs && _e_wb_src != LOAD_SRC)
         return 2'd1;
      else if (_m_valid && _m_wb_we && _m_rd != 5'd0 && _m_rd == rs)
         return 2'd2;
      else
         return 2'd0;
   endfunction

   // Output logic
   always_comb begin
      sig_lw_blocked_ = 1'b0;
      sig_flush_      = 1'b0;
      fwd_rs1_sel_    = 2'd0;
      fwd_rs2_sel_    = 2'd0;
      unique case (state_q)
         StIdle: begin
            sig_flush_      = br & ~eb;
            sig_lw_blocked_ = lu & ~eb & ~br;
         end
         StLwStall: sig_flush_ = br & ~eb;
         StBrFlush: sig_flush_ = 1'b1;
         StHalt: begin
            sig_lw_blocked_ = 1'b1;
            sig_flush_      = 1'b1;
         end
         default: ;
      endcase
      if (state_q != StHalt) begin
         fwd_rs1_sel_ = fwd_sel(_d_rs1);
         fwd_rs2_sel_ = fwd_sel(_d_rs2);
      end
   end

   assign halted_ = halted_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_q, flush_q;

   always_ff @(posedge _clk) begin
      if (_rst) begin
         stall_q <= 32'd0;
         flush_q <= 32'd0;
      end else if (state_q != StHalt) begin
         if (sig_lw_blocked_ && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
         if (sig_flush_ && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cycles_ = stall_q;
   assign flush_cycles_ = flush_q;
`else
   assign stall_cycles_ = 32'd0;
   assign flush_cycles_ = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
// (BRANCH_SHADOW=2, LOAD_SRC=2'b01). Inputs change on the falling edge and
// outputs are checked 1 time unit later.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        d_valid, d_use_rs1, d_use_rs2;
   logic [4:0]  d_rs1, d_rs2;
   logic        e_valid, e_wb_we, e_branch_taken;
   logic [4:0]  e_rd;
   logic [1:0]  e_wb_src;
   logic        m_valid, m_wb_we, m_ebreak;
   logic [4:0]  m_rd;
   logic        blocked, flush, halted;
   logic [1:0]  sel1, sel2;
   logic [31:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      ._clk            (clk),
      ._rst            (rst),
      ._d_valid        (d_valid),
      ._d_rs1          (d_rs1),
      ._d_rs2          (d_rs2),
      ._d_use_rs1      (d_use_rs1),
      ._d_use_rs2      (d_use_rs2),
      ._e_valid        (e_valid),
      ._e_rd           (e_rd),
      ._e_wb_we        (e_wb_we),
      ._e_wb_src       (e_wb_src),
      ._e_branch_taken (e_branch_taken),
      ._m_valid        (m_valid),
      ._m_rd           (m_rd),
      ._m_wb_we        (m_wb_we),
      ._m_ebreak       (m_ebreak),
      .sig_lw_blocked_ (blocked),
      .sig_flush_      (flush),
      .fwd_rs1_sel_    (sel1),
      .fwd_rs2_sel_    (sel2),
      .halted_         (halted),
      .stall_cycles_   (stall_cnt),
      .flush_cycles_   (flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_use_rs1 = 0; d_use_rs2 = 0;
      e_valid = 0; e_rd = 0; e_wb_we = 0; e_wb_src = 0; e_branch_taken = 0;
      m_valid = 0; m_rd = 0; m_wb_we = 0; m_ebreak = 0;
   endtask

   task automatic load_in_e(input logic [4:0] rd);
      e_valid = 1; e_rd = rd; e_wb_we = 1; e_wb_src = 2'b01;
   endtask

   task automatic check_perf(input string tag, input logic [31:0] st, input logic [31:0] fl);
`ifdef HAZARD_PERF_EN
      check({tag, "_stall_cnt"}, stall_cnt, st);
      check({tag, "_flush_cnt"}, flush_cnt, fl);
`else
      check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
      check({tag, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
   endtask

   initial begin
      // Reset
      rst = 1; clear_inputs();
      @(negedge clk); @(negedge clk);
      rst = 0; #1;
      check("rst_blocked", {31'd0, blocked}, 0);
      check("rst_flush", {31'd0, flush}, 0);
      check("rst_sel1", {30'd0, sel1}, 0);
      check("rst_sel2", {30'd0, sel2}, 0);
      check("rst_halted", {31'd0, halted}, 0);
      check_perf("rst", 0, 0);

      // lw x5 in E; add x6,x5,x1 in D -> one stall
      @(negedge clk); clear_inputs();
      load_in_e(5'd5);
      d_valid = 1; d_rs1 = 5; d_use_rs1 = 1; d_rs2 = 1; d_use_rs2 = 1; #1;
      check("lu_blocked", {31'd0, blocked}, 1);
      check("lu_flush", {31'd0, flush}, 0);
      check("lu_sel1_no_e_fwd", {30'd0, sel1}, 0);
      // Load now in M; stale load left in E must not restall
      @(negedge clk);
      m_valid = 1; m_rd = 5; m_wb_we = 1; #1;
      check("lustall_blocked", {31'd0, blocked}, 0);
      check("lustall_sel1", {30'd0, sel1}, 2);
      check("lustall_sel2", {30'd0, sel2}, 0);
      @(negedge clk); clear_inputs(); #1;
      check("lu_after_blocked", {31'd0, blocked}, 0);

      // ALU result in E forwarded; E beats M
      @(negedge clk); clear_inputs();
      e_valid = 1; e_rd = 7; e_wb_we = 1; e_wb_src = 2'b00;
      d_valid = 1; d_rs1 = 7; d_use_rs1 = 1; d_rs2 = 7; d_use_rs2 = 1;
      m_valid = 1; m_rd = 7; m_wb_we = 1; #1;
      check("alu_blocked", {31'd0, blocked}, 0);
      check("alu_sel1_e_over_m", {30'd0, sel1}, 1);
      check("alu_sel2_e_over_m", {30'd0, sel2}, 1);
      m_rd = 9; d_rs2 = 9; #1;
      check("alu_sel1_e", {30'd0, sel1}, 1);
      check("alu_sel2_m", {30'd0, sel2}, 2);
      m_wb_we = 0; #1;
      check("alu_sel2_m_nowe", {30'd0, sel2}, 0);

      // x0 never stalls or forwards
      @(negedge clk); clear_inputs();
      load_in_e(5'd0);
      d_valid = 1; d_use_rs1 = 1; d_use_rs2 = 1;
      m_valid = 1; m_rd = 0; m_wb_we = 1; #1;
      check("x0_blocked", {31'd0, blocked}, 0);
      check("x0_sel1", {30'd0, sel1}, 0);
      check("x0_sel2", {30'd0, sel2}, 0);

      // Load-use through rs2
      @(negedge clk); clear_inputs();
      load_in_e(5'd3);
      d_valid = 1; d_rs1 = 4; d_use_rs1 = 1; d_rs2 = 3; d_use_rs2 = 1; #1;
      check("lu2_blocked", {31'd0, blocked}, 1);
      @(negedge clk); clear_inputs(); #1;
      check("lu2_stall_blocked", {31'd0, blocked}, 0);

      // Taken branch: 2 flush cycles, load-use suppressed during shadow
      @(negedge clk); clear_inputs();
      e_valid = 1; e_branch_taken = 1; #1;
      check("br0_flush", {31'd0, flush}, 1);
      check("br0_blocked", {31'd0, blocked}, 0);
      @(negedge clk); clear_inputs();
      load_in_e(5'd5);
      d_valid = 1; d_rs1 = 5; d_use_rs1 = 1; #1;
      check("br1_flush", {31'd0, flush}, 1);
      check("br1_blocked", {31'd0, blocked}, 0);
      @(negedge clk); #1;
      check("br2_flush", {31'd0, flush}, 0);
      check("br2_blocked", {31'd0, blocked}, 1);
      @(negedge clk); clear_inputs(); #1;
      check("br3_flush", {31'd0, flush}, 0);
      check("br3_blocked", {31'd0, blocked}, 0);
      check_perf("perf", 3, 2);

      // ebreak in M beats taken branch; halt next cycle
      @(negedge clk); clear_inputs();
      m_valid = 1; m_ebreak = 1; e_valid = 1; e_branch_taken = 1; #1;
      check("eb_flush", {31'd0, flush}, 0);
      check("eb_halted", {31'd0, halted}, 0);
      @(negedge clk); clear_inputs();
      e_valid = 1; e_rd = 7; e_wb_we = 1; d_valid = 1; d_rs1 = 7; d_use_rs1 = 1; #1;
      check("halt_halted", {31'd0, halted}, 1);
      check("halt_blocked", {31'd0, blocked}, 1);
      check("halt_flush", {31'd0, flush}, 1);
      check("halt_sel1", {30'd0, sel1}, 0);
      @(negedge clk); clear_inputs(); #1;
      check("halt_sticky", {31'd0, halted}, 1);
      check_perf("halt", 3, 2);

      // Reset out of HALT
      rst = 1;
      @(negedge clk);
      rst = 0; #1;
      check("rst2_halted", {31'd0, halted}, 0);
      check("rst2_blocked", {31'd0, blocked}, 0);
      check("rst2_flush", {31'd0, flush}, 0);
      check_perf("rst2", 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
